mem_except_unit: RTL and testbench
==================================

# mem_except_unit

Memory-stage address exception unit for the MIPS pipeline: classifies every load/store in M stage for alignment (and optionally privilege) faults, suppresses the faulting memory access in the same cycle, and holds a registered exception request with BadVAddr/EPC/BD until CP0 accepts it. It sits between the M-stage pipeline register, the data-memory interface and CP0. It replaces the purely combinational AdEL/AdES flagging with a latched, handshaked request and a fault counter.

## Interface
- ADDR_W, 32, width of virtual address and PC
- CNT_W, 16, width of the saturating fault counter
- clk  in  1  pipeline clock
- resetn  in  1  synchronous, active-low reset
- valid_i  in  1  M-stage instruction valid
- stall_i  in  1  M stage held this cycle; no new capture
- flush_i  in  1  squash M-stage instruction
- opM  in  6  M-stage opcode
- addr_i  in  ADDR_W  effective data address
- pc_i  in  ADDR_W  PC of M-stage instruction
- bd_i  in  1  instruction is in a branch delay slot
- user_mode_i  in  1  CPU in user mode (used only with range check)
- mem_en_o  out  1  data-memory enable, fault-suppressed
- exc_req_o  out  1  exception request to CP0, held until acked
- exc_ack_i  in  1  CP0 accepts request
- excode_o  out  5  0x04 AdEL, 0x05 AdES
- badvaddr_o  out  ADDR_W  faulting address
- epc_o  out  ADDR_W  PC of faulting instruction
- bd_o  out  1  latched bd_i
- pipe_flush_o  out  1  one-cycle flush pulse after ack
- fault_cnt_o  out  CNT_W  saturating count of accepted faults

## Operation
- Memory ops: LB, LBU, LH, LHU, LW (loads); SB, SH, SW (stores). Other opcodes never fault, mem_en_o=0.
- Alignment: byte never faults; half faults when addr_i[0]=1; word faults when addr_i[1:0]!=00.
- fault = valid_i & ~flush_i & memop & misaligned (| range fault when enabled). Load fault -> AdEL, store fault -> AdES.
- mem_en_o = valid_i & ~flush_i & memop & ~fault & (state==IDLE); combinational, same cycle.
- States: IDLE, PENDING, FLUSH.
- IDLE: if fault & ~stall_i -> capture excode, addr_i, pc_i, bd_i; go PENDING. flush_i or stall_i blocks capture.
- PENDING: exc_req_o=1, captured fields stable; inputs ignored (incl. flush_i); mem_en_o=0. exc_ack_i -> FLUSH, fault_cnt_o += 1 unless all ones.
- FLUSH: pipe_flush_o=1 for exactly one cycle, exc_req_o=0; -> IDLE unconditionally. No capture in FLUSH.
- fault_cnt_o saturates at 2^CNT_W-1; never wraps.

## Timing
- Fault detect to exc_req_o: 1 cycle (registered). Memory suppression: 0 cycles.
- exc_ack_i sampled only in PENDING; ack in same cycle req rises is legal -> FLUSH next cycle. Minimum IDLE->IDLE round trip 3 cycles.
- Reset (resetn=0 at rising edge, any state): state IDLE; exc_req_o=0, pipe_flush_o=0, excode_o=0, badvaddr_o=0, epc_o=0, bd_o=0, fault_cnt_o=0. mem_en_o follows its equation (0 while in reset since state forced IDLE next cycle; combinationally gated by resetn).
- Reset mid-PENDING drops the request with no flush pulse and no count.

## Configuration
- ADDR_RANGE_CHECK_EN defined: when user_mode_i=1 and addr_i[ADDR_W-1]=1, access faults (AdEL/AdES by direction) even if aligned; alignment and range faults share one code. Undefined: user_mode_i ignored, only alignment faults.

## Structure
- Package mem_except_pkg: opcode constants (LB..SW), EXC_ADEL=5'h04, EXC_ADES=5'h05, state enum.
- Sub-module align_check: combinational opcode/address classifier producing is_load, is_store, fault.

## Test plan
- LW at 0x8000_0002, valid, no stall -> mem_en_o=0 same cycle; next cycle exc_req_o=1, excode_o=0x04, badvaddr_o=0x8000_0002.
- SH at 0x0000_1001, ack two cycles later -> excode 0x05 held stable, pipe_flush_o one-cycle pulse, fault_cnt_o 0->1.
- SB at 0x0000_1003 and LH at 0x0000_1002 -> no fault, mem_en_o=1, exc_req_o stays 0.
- LW misaligned with stall_i=1 then flush_i=1 -> never captured, exc_req_o=0, count unchanged.
- ADDR_RANGE_CHECK_EN, user_mode_i=1, LW 0x8000_0000 -> AdEL; same access user_mode_i=0 -> no fault; macro off -> no fault.
- Preload counter to 0xFFFF, one more acked fault -> stays 0xFFFF; resetn=0 in PENDING -> all outputs zero next cycle.

Source files
------------

// File: rtl/mem_except_pkg.sv
// mem_except_pkg: shared opcodes, exception codes and FSM state type for the M-stage exception unit
package mem_except_pkg;
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2B;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    typedef enum logic [1:0] {S_IDLE, S_PENDING, S_FLUSH} state_e;
endpackage

// File: rtl/mem_except_unit_align_check.sv
// align_check: combinational load/store classifier and address fault detector
//   op_i         M-stage opcode
//   addr_lo_i    effective address bits [1:0]
//   addr_msb_i   effective address MSB (kernel segment)
//   user_mode_i  CPU in user mode
//   is_load_o / is_store_o  opcode direction
//   fault_o      memory op with misaligned (or, with ADDR_RANGE_CHECK_EN, privileged) address
module align_check
    import mem_except_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [1:0] addr_lo_i,
    input  logic       addr_msb_i,
    input  logic       user_mode_i,
    output logic       is_load_o,
    output logic       is_store_o,
    output logic       fault_o
);
    logic range_fault;
`ifdef ADDR_RANGE_CHECK_EN
    assign range_fault = user_mode_i & addr_msb_i;
`else
    logic unused_range;
    assign unused_range = user_mode_i & addr_msb_i;
    assign range_fault = 1'b0;
`endif
    logic half, word, misaligned;
    always_comb begin
        is_load_o  = op_i inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
        is_store_o = op_i inside {OP_SB, OP_SH, OP_SW};
        half       = op_i inside {OP_LH, OP_LHU, OP_SH};
        word       = op_i inside {OP_LW, OP_SW};
        misaligned = (half & addr_lo_i[0]) | (word & |addr_lo_i);
        fault_o    = (is_load_o | is_store_o) & (misaligned | range_fault);
    end
endmodule

// File: rtl/mem_except_unit.sv
// mem_except_unit: M-stage address exception unit with latched, handshaked CP0 request
//   clk, resetn (sync, active-low)
//   valid_i, stall_i, flush_i, opM, addr_i, pc_i, bd_i, user_mode_i : M-stage instruction
//   mem_en_o      data-memory enable, suppressed on fault in the same cycle
//   exc_req_o / exc_ack_i : request to CP0, held until accepted
//   excode_o, badvaddr_o, epc_o, bd_o : captured exception fields
//   pipe_flush_o  one-cycle pulse after ack
//   fault_cnt_o   saturating count of accepted faults
//   Optional macro ADDR_RANGE_CHECK_EN adds user-mode kernel-address faults.
module mem_except_unit
    import mem_except_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [5:0]        opM,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              bd_i,
    input  logic              user_mode_i,
    output logic              mem_en_o,
    output logic              exc_req_o,
    input  logic              exc_ack_i,
    output logic [4:0]        excode_o,
    output logic [ADDR_W-1:0] badvaddr_o,
    output logic [ADDR_W-1:0] epc_o,
    output logic              bd_o,
    output logic              pipe_flush_o,
    output logic [CNT_W-1:0]  fault_cnt_o
);
    logic is_load, is_store, raw_fault, fault, capture, count;
    state_e state_q, state_d;
    logic [4:0] excode_q, excode_d;
    logic [ADDR_W-1:0] badvaddr_q, badvaddr_d, epc_q, epc_d;
    logic bd_q, bd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    align_check u_align (
        .op_i       (opM),
        .addr_lo_i  (addr_i[1:0]),
        .addr_msb_i (addr_i[ADDR_W-1]),
        .user_mode_i(user_mode_i),
        .is_load_o  (is_load),
        .is_store_o (is_store),
        .fault_o    (raw_fault)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= S_IDLE;
            excode_q   <= '0;
            badvaddr_q <= '0;
            epc_q      <= '0;
            bd_q       <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            excode_q   <= excode_d;
            badvaddr_q <= badvaddr_d;
            epc_q      <= epc_d;
            bd_q       <= bd_d;
            cnt_q      <= cnt_d;
        end
    end

    // Fields are captured only on the IDLE->PENDING edge, so they stay stable while the request is held.
    always_comb begin
        fault      = valid_i & ~flush_i & raw_fault;
        capture    = (state_q == S_IDLE) & fault & ~stall_i;
        count      = (state_q == S_PENDING) & exc_ack_i;
        state_d    = (state_q == S_IDLE)    ? (capture   ? S_PENDING : S_IDLE)
                   : (state_q == S_PENDING) ? (exc_ack_i ? S_FLUSH   : S_PENDING)
                   : S_IDLE;
        excode_d   = capture ? (is_load ? EXC_ADEL : EXC_ADES) : excode_q;
        badvaddr_d = capture ? addr_i : badvaddr_q;
        epc_d      = capture ? pc_i : epc_q;
        bd_d       = capture ? bd_i : bd_q;
        cnt_d      = (count && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_comb begin
        mem_en_o     = resetn & valid_i & ~flush_i & (is_load | is_store) & ~fault & (state_q == S_IDLE);
        exc_req_o    = state_q == S_PENDING;
        pipe_flush_o = state_q == S_FLUSH;
        excode_o     = excode_q;
        badvaddr_o   = badvaddr_q;
        epc_o        = epc_q;
        bd_o         = bd_q;
        fault_cnt_o  = cnt_q;
    end
endmodule

// File: tb/tb_mem_except_unit.sv
// tb_mem_except_unit: directed self-checking bench for mem_except_unit (narrow counter to reach saturation)
module tb_mem_except_unit;
    localparam int CW = 4;
    logic clk = 1'b0, resetn, valid_i, stall_i, flush_i, bd_i, user_mode_i, exc_ack_i;
    logic [5:0] opM;
    logic [31:0] addr_i, pc_i, badvaddr_o, epc_o;
    logic mem_en_o, exc_req_o, bd_o, pipe_flush_o;
    logic [4:0] excode_o;
    logic [CW-1:0] fault_cnt_o;
    int n_cmp = 0, n_bad = 0;
    logic exp_rng;
    logic [CW-1:0] exp_cnt;

    mem_except_unit #(.ADDR_W(32), .CNT_W(CW)) dut (
        .clk(clk), .resetn(resetn), .valid_i(valid_i), .stall_i(stall_i), .flush_i(flush_i),
        .opM(opM), .addr_i(addr_i), .pc_i(pc_i), .bd_i(bd_i), .user_mode_i(user_mode_i),
        .mem_en_o(mem_en_o), .exc_req_o(exc_req_o), .exc_ack_i(exc_ack_i), .excode_o(excode_o),
        .badvaddr_o(badvaddr_o), .epc_o(epc_o), .bd_o(bd_o), .pipe_flush_o(pipe_flush_o),
        .fault_cnt_o(fault_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [31:0] a);
        valid_i = v;
        opM = op;
        addr_i = a;
        #1;
    endtask

    initial begin
`ifdef ADDR_RANGE_CHECK_EN
        exp_rng = 1'b1;
`else
        exp_rng = 1'b0;
`endif
        resetn = 0; stall_i = 0; flush_i = 0; bd_i = 0; user_mode_i = 0; exc_ack_i = 0; pc_i = 0;
        drive(1, 6'h23, 32'h0000_1000);
        tick(); tick();
        chk("rst_mem_en", mem_en_o, 0);
        chk("rst_req", exc_req_o, 0);
        chk("rst_flush", pipe_flush_o, 0);
        chk("rst_excode", excode_o, 0);
        chk("rst_badv", badvaddr_o, 0);
        chk("rst_epc", epc_o, 0);
        chk("rst_bd", bd_o, 0);
        chk("rst_cnt", fault_cnt_o, 0);
        resetn = 1;
        drive(0, 6'h00, 0);
        tick();

        // LW misaligned -> AdEL
        pc_i = 32'h0000_0400; bd_i = 1;
        drive(1, 6'h23, 32'h8000_0002);
        chk("lw_mis_mem_en", mem_en_o, 0);
        tick();
        bd_i = 0; pc_i = 32'h0000_0999;
        drive(1, 6'h23, 32'h0000_2000);
        chk("lw_req", exc_req_o, 1);
        chk("lw_excode", excode_o, 5'h04);
        chk("lw_badv", badvaddr_o, 32'h8000_0002);
        chk("lw_epc", epc_o, 32'h0000_0400);
        chk("lw_bd", bd_o, 1);
        chk("pend_mem_en", mem_en_o, 0);
        exc_ack_i = 1;
        tick();
        chk("ack_flush", pipe_flush_o, 1);
        chk("ack_req", exc_req_o, 0);
        chk("ack_cnt", fault_cnt_o, 1);
        chk("flush_mem_en", mem_en_o, 0);
        exc_ack_i = 0;
        drive(0, 6'h00, 0);
        tick();
        chk("flush_end", pipe_flush_o, 0);
        chk("idle_req", exc_req_o, 0);

        // SH misaligned -> AdES, ack two cycles later
        pc_i = 32'h0000_0404;
        drive(1, 6'h29, 32'h0000_1001);
        chk("sh_mem_en", mem_en_o, 0);
        tick();
        drive(0, 6'h00, 0);
        chk("sh_req", exc_req_o, 1);
        chk("sh_excode", excode_o, 5'h05);
        tick();
        chk("sh_req_hold", exc_req_o, 1);
        chk("sh_excode_hold", excode_o, 5'h05);
        chk("sh_badv_hold", badvaddr_o, 32'h0000_1001);
        exc_ack_i = 1;
        tick();
        exc_ack_i = 0;
        chk("sh_flush", pipe_flush_o, 1);
        chk("sh_cnt", fault_cnt_o, 2);
        tick();
        chk("sh_flush_end", pipe_flush_o, 0);

        // aligned byte and half accesses
        drive(1, 6'h28, 32'h0000_1003);
        chk("sb_mem_en", mem_en_o, 1);
        tick();
        chk("sb_req", exc_req_o, 0);
        drive(1, 6'h21, 32'h0000_1002);
        chk("lh_mem_en", mem_en_o, 1);
        tick();
        chk("lh_req", exc_req_o, 0);
        drive(1, 6'h0F, 32'h0000_1001);
        chk("nonmem_mem_en", mem_en_o, 0);
        tick();
        chk("nonmem_req", exc_req_o, 0);

        // stall then flush block capture
        stall_i = 1;
        drive(1, 6'h23, 32'h0000_1001);
        chk("stall_mem_en", mem_en_o, 0);
        tick();
        chk("stall_req", exc_req_o, 0);
        stall_i = 0; flush_i = 1;
        #1;
        chk("flush_mem_en_in", mem_en_o, 0);
        tick();
        chk("flushin_req", exc_req_o, 0);
        chk("flushin_cnt", fault_cnt_o, 2);
        flush_i = 0;

        // kernel address from user mode
        user_mode_i = 1;
        drive(1, 6'h23, 32'h8000_0000);
        chk("rng_mem_en", mem_en_o, !exp_rng);
        tick();
        drive(0, 6'h00, 0);
        chk("rng_req", exc_req_o, exp_rng);
        exc_ack_i = 1;
        tick();
        exc_ack_i = 0;
        chk("rng_flush", pipe_flush_o, exp_rng);
        tick();
        exp_cnt = CW'(2) + CW'(exp_rng);
        chk("rng_cnt", fault_cnt_o, exp_cnt);
        user_mode_i = 0;
        drive(1, 6'h23, 32'h8000_0000);
        chk("kern_mem_en", mem_en_o, 1);
        tick();
        chk("kern_req", exc_req_o, 0);

        // ack asserted in the same cycle the request rises; saturate counter
        for (int i = 0; i < 20; i++) begin
            exc_ack_i = 1;
            drive(1, 6'h2B, 32'h0000_0002);
            tick();
            drive(0, 6'h00, 0);
            tick();
            exc_ack_i = 0;
            tick();
        end
        chk("sat_cnt", fault_cnt_o, {CW{1'b1}});
        chk("sat_idle_req", exc_req_o, 0);

        // reset while pending
        drive(1, 6'h21, 32'h0000_0003);
        tick();
        drive(0, 6'h00, 0);
        chk("pre_rst_req", exc_req_o, 1);
        resetn = 0; exc_ack_i = 1;
        tick();
        chk("midrst_req", exc_req_o, 0);
        chk("midrst_flush", pipe_flush_o, 0);
        chk("midrst_excode", excode_o, 0);
        chk("midrst_badv", badvaddr_o, 0);
        chk("midrst_cnt", fault_cnt_o, 0);
        resetn = 1; exc_ack_i = 0;
        tick();
        chk("postrst_flush", pipe_flush_o, 0);
        chk("postrst_req", exc_req_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
